// File: rtl/conv_window_scheduler_pkg.sv
// rtl/conv_window_scheduler_pkg.sv - state encoding and dimension helpers for the convolution sequencer
package conv_window_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    COMPUTE = 3'd2,
    EMIT    = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Counter/index width; never below one bit so single-entry dimensions still have a port.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int out_dim(input int in_dim, input int filt, input int stride);
    return (in_dim - filt) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// rtl/conv_pos_counter.sv - nested channel/column/row position counter, channel fastest
module conv_pos_counter
  import conv_window_scheduler_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int CHANS = 2,
  localparam int RW   = cw(ROWS),
  localparam int CLW  = cw(COLS),
  localparam int CHW  = cw(CHANS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           inc,
  output logic [RW-1:0]  row,
  output logic [CLW-1:0] col,
  output logic [CHW-1:0] ch,
  output logic           ch_last,
  output logic           col_last,
  output logic           pass_last
);

  logic row_last;

  assign ch_last   = (ch == CHW'(CHANS - 1));
  assign col_last  = (col == CLW'(COLS - 1));
  assign row_last  = (row == RW'(ROWS - 1));
  assign pass_last = ch_last && col_last && row_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
      ch  <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
      ch  <= '0;
    end else if (inc) begin
      if (!ch_last) begin
        ch <= ch + 1'b1;
      end else begin
        ch <= '0;
        if (!col_last) begin
          col <= col + 1'b1;
        end else begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/conv_window_scheduler.sv
// rtl/conv_window_scheduler.sv - window fetch / kernel result sequencer; CONV_RELU_EN clamps negative results to zero
module conv_window_scheduler
  import conv_window_scheduler_pkg::*;
#(
  parameter int  BITWIDTH     = 8,
  parameter int  IN_HEIGHT    = 32,
  parameter int  IN_WIDTH     = 32,
  parameter int  FILTERHEIGHT = 5,
  parameter int  FILTERWIDTH  = 5,
  parameter int  OUTCHANNEL   = 6,
  parameter int  STRIDE       = 1,
  localparam int OUT_H        = out_dim(IN_HEIGHT, FILTERHEIGHT, STRIDE),
  localparam int OUT_W        = out_dim(IN_WIDTH, FILTERWIDTH, STRIDE),
  localparam int IRW          = cw(IN_HEIGHT),
  localparam int ICW          = cw(IN_WIDTH),
  localparam int CHW          = cw(OUTCHANNEL),
  localparam int ORW          = cw(OUT_H),
  localparam int OCW          = cw(OUT_W),
  localparam int DW           = 2 * BITWIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 win_req,
  output logic [IRW-1:0]       win_row,
  output logic [ICW-1:0]       win_col,
  input  logic                 win_ack,
  output logic [CHW-1:0]       w_sel,
  input  logic signed [DW-1:0] kernel_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic [ORW-1:0]       out_row,
  output logic [OCW-1:0]       out_col,
  output logic [CHW-1:0]       out_ch
);

  localparam logic [IRW-1:0] ROW_STEP = IRW'(STRIDE);
  localparam logic [ICW-1:0] COL_STEP = ICW'(STRIDE);

  state_t state, state_nxt;

  logic           cnt_clr;
  logic           cnt_inc;
  logic           capture;
  logic [ORW-1:0] row;
  logic [OCW-1:0] col;
  logic [CHW-1:0] ch;
  logic           ch_last;
  logic           col_last;
  logic           pass_last;

  logic signed [DW-1:0] result_d;

  conv_pos_counter #(
    .ROWS  (OUT_H),
    .COLS  (OUT_W),
    .CHANS (OUTCHANNEL)
  ) u_pos (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .row       (row),
    .col       (col),
    .ch        (ch),
    .ch_last   (ch_last),
    .col_last  (col_last),
    .pass_last (pass_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_clr   = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (win_ack) begin
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        capture   = 1'b1;
        state_nxt = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          if (pass_last) begin
            state_nxt = DONE;
          end else begin
            // Remaining channels reuse the window already on the kernel bus.
            cnt_inc   = 1'b1;
            state_nxt = ch_last ? FETCH : COMPUTE;
          end
        end
      end
      DONE: begin
        cnt_clr   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state == FETCH) || (state == COMPUTE) || (state == EMIT);
  assign win_req   = (state == FETCH);
  assign out_valid = (state == EMIT);
  assign done      = (state == DONE);
  assign w_sel     = ch;

  // Window origin steps alongside the position counter so no multiplier is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_row <= '0;
      win_col <= '0;
    end else if (cnt_clr) begin
      win_row <= '0;
      win_col <= '0;
    end else if (cnt_inc && ch_last) begin
      if (col_last) begin
        win_col <= '0;
        win_row <= win_row + ROW_STEP;
      end else begin
        win_col <= win_col + COL_STEP;
      end
    end
  end

`ifdef CONV_RELU_EN
  assign result_d = kernel_result[DW-1] ? '0 : kernel_result;
`else
  assign result_d = kernel_result;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_row  <= '0;
      out_col  <= '0;
      out_ch   <= '0;
    end else if (capture) begin
      out_data <= result_d;
      out_row  <= row;
      out_col  <= col;
      out_ch   <= ch;
    end
  end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb/tb_conv_window_scheduler.sv - directed bench for conv_window_scheduler (stride 1 and stride 2 instances)
module tb_conv_window_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // 6x6 input, 3x3 filter, 2 channels, stride 1 -> 4x4x2 outputs
  logic        start1 = 1'b0, win_ack1 = 1'b0, out_ready1 = 1'b1;
  logic        busy1, done1, win_req1, out_valid1;
  logic [2:0]  win_row1, win_col1;
  logic [0:0]  w_sel1, out_ch1;
  logic [15:0] kr1, out_data1;
  logic [1:0]  out_row1, out_col1;

  // 7x7 input, 3x3 filter, 1 channel, stride 2 -> 3x3x1 outputs
  logic        start2 = 1'b0, win_ack2 = 1'b0, out_ready2 = 1'b1;
  logic        busy2, done2, win_req2, out_valid2;
  logic [2:0]  win_row2, win_col2;
  logic [0:0]  w_sel2, out_ch2;
  logic [15:0] kr2, out_data2;
  logic [1:0]  out_row2, out_col2;

  logic        kr_ovr = 1'b0;
  logic [15:0] kr_val = '0;
  int          ack_delay = 1;

`ifdef CONV_RELU_EN
  localparam logic [15:0] NEG_EXP = 16'h0000;
`else
  localparam logic [15:0] NEG_EXP = 16'hFFFB;
`endif

  function automatic logic [15:0] kmodel(input int r, input int c, input int ch);
    return 16'(r * 100 + c * 10 + ch + 1);
  endfunction

  assign kr1 = kr_ovr ? kr_val : kmodel(int'(win_row1), int'(win_col1), int'(w_sel1));
  assign kr2 = kmodel(int'(win_row2), int'(win_col2), int'(w_sel2));

  conv_window_scheduler #(
    .BITWIDTH(8), .IN_HEIGHT(6), .IN_WIDTH(6), .FILTERHEIGHT(3), .FILTERWIDTH(3),
    .OUTCHANNEL(2), .STRIDE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .win_req(win_req1), .win_row(win_row1), .win_col(win_col1), .win_ack(win_ack1),
    .w_sel(w_sel1), .kernel_result(kr1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_row(out_row1), .out_col(out_col1), .out_ch(out_ch1)
  );

  conv_window_scheduler #(
    .BITWIDTH(8), .IN_HEIGHT(7), .IN_WIDTH(7), .FILTERHEIGHT(3), .FILTERWIDTH(3),
    .OUTCHANNEL(1), .STRIDE(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .win_req(win_req2), .win_row(win_row2), .win_col(win_col2), .win_ack(win_ack2),
    .w_sel(w_sel2), .kernel_result(kr2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_row(out_row2), .out_col(out_col2), .out_ch(out_ch2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int wait1 = 0, wait2 = 0;
  always @(negedge clk) begin
    if (win_req1 && !win_ack1) begin
      if (wait1 >= ack_delay) win_ack1 = 1'b1;
      else wait1++;
    end else begin
      win_ack1 = 1'b0;
      wait1 = 0;
    end
    if (win_req2 && !win_ack2) begin
      if (wait2 >= 1) win_ack2 = 1'b1;
      else wait2++;
    end else begin
      win_ack2 = 1'b0;
      wait2 = 0;
    end
  end

  int beats1 = 0, fetch1 = 0, dones1 = 0, hs_cyc1 = 0, done_cyc1 = 0;
  int er1 = 0, ec1 = 0, ech1 = 0;
  int beats2 = 0, fetch2 = 0, dones2 = 0;
  int er2 = 0, ec2 = 0;

  // Handshakes seen here complete at the following rising edge.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      er1 = 0; ec1 = 0; ech1 = 0; er2 = 0; ec2 = 0;
    end else begin
      if (win_req1 && win_ack1) begin
        check("fetch1_pos", {win_row1, win_col1, w_sel1}, {3'(er1), 3'(ec1), 1'b0});
        fetch1++;
      end
      if (out_valid1 && out_ready1) begin
        check("beat1_pos", {out_row1, out_col1, out_ch1}, {2'(er1), 2'(ec1), 1'(ech1)});
        if (!kr_ovr) check("beat1_data", out_data1, kmodel(er1, ec1, ech1));
        beats1++;
        hs_cyc1 = cyc;
        ech1++;
        if (ech1 == 2) begin
          ech1 = 0; ec1++;
          if (ec1 == 4) begin ec1 = 0; er1 = (er1 + 1) % 4; end
        end
      end
      if (done1) begin dones1++; done_cyc1 = cyc; end
      if (win_req2 && win_ack2) begin
        check("fetch2_pos", {win_row2, win_col2}, {3'(er2 * 2), 3'(ec2 * 2)});
        fetch2++;
      end
      if (out_valid2 && out_ready2) begin
        check("beat2_pos", {out_row2, out_col2, out_ch2}, {2'(er2), 2'(ec2), 1'b0});
        check("beat2_data", out_data2, kmodel(er2 * 2, ec2 * 2, 0));
        beats2++;
        ec2++;
        if (ec2 == 3) begin ec2 = 0; er2 = (er2 + 1) % 3; end
      end
      if (done2) dones2++;
    end
  end

  function automatic bit cond(input int kind, input int ref_cnt);
    case (kind)
      0: return out_valid1;
      1: return win_req1;
      2: return dones1 != ref_cnt;
      3: return dones2 != ref_cnt;
      default: return beats1 >= ref_cnt;
    endcase
  endfunction

  task automatic wait_until(input string tag, input int kind, input int ref_cnt, input int limit);
    int n = 0;
    while (!cond(kind, ref_cnt) && n < limit) begin
      @(negedge clk); #3;
      n++;
    end
    check(tag, 32'(cond(kind, ref_cnt)), 32'd1);
  endtask

  task automatic pulse_start1();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; #3;
  endtask

  int b0, f0, d0, reqc;
  logic [31:0] snap;

  initial begin
    repeat (3) @(negedge clk);
    #3;
    check("rst_ctl1", {busy1, done1, win_req1, out_valid1}, 0);
    check("rst_pos1", {win_row1, win_col1, w_sel1, out_row1, out_col1, out_ch1}, 0);
    check("rst_data1", out_data1, 0);
    check("rst_all2", {busy2, done2, win_req2, out_valid2, win_row2, win_col2, out_data2}, 0);

    // Full stride-1 pass and stride-2 pass side by side; a second start mid-pass is ignored
    @(negedge clk); rst_n = 1'b1;
    b0 = beats1; f0 = fetch1; d0 = dones1;
    @(negedge clk); start1 = 1'b1; start2 = 1'b1;
    @(negedge clk); start1 = 1'b0; start2 = 1'b0; #3;
    check("busy_after_start", {busy1, busy2}, 2'b11);
    repeat (10) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; #3;
    wait_until("done1_timeout", 2, d0, 3000);
    check("beats_pass1", beats1 - b0, 32);
    check("fetch_pass1", fetch1 - f0, 16);
    check("done_after_last_hs", done_cyc1, hs_cyc1 + 1);
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; #3;
    check("idle_after_done", {busy1, done1, win_req1}, 0);
    @(negedge clk); #3;
    check("start_in_done_ignored", {busy1, win_req1}, 0);
    check("one_done_pulse", dones1 - d0, 1);
    wait_until("done2_timeout", 3, 0, 500);
    check("beats_pass2", beats2, 9);
    check("fetch_pass2", fetch2, 9);
    check("busy2_low", busy2, 0);

    // Delayed ack then backpressure on the first beat
    ack_delay = 3; out_ready1 = 1'b0;
    b0 = beats1; f0 = fetch1; d0 = dones1;
    pulse_start1();
    wait_until("req_timeout", 1, 0, 20);
    reqc = 0;
    while (!win_ack1 && reqc < 10) begin
      check("req_hold", {win_req1, win_row1, win_col1}, {1'b1, 6'd0});
      reqc++;
      @(negedge clk); #3;
    end
    check("ack_wait_cycles", reqc, 3);
    @(negedge clk); #3;
    check("valid_low_in_compute", out_valid1, 0);
    @(negedge clk); #3;
    check("valid_2_after_ack", out_valid1, 1);
    snap = {out_data1, 5'(out_row1), 5'(out_col1), 3'(out_ch1), 3'(w_sel1)};
    check("first_beat_value", snap, {kmodel(0, 0, 0), 16'd0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #3;
      check("bp_stable", {out_data1, 5'(out_row1), 5'(out_col1), 3'(out_ch1), 3'(w_sel1)}, snap);
      check("bp_valid_noreq", {out_valid1, win_req1}, 2'b10);
    end
    @(negedge clk); out_ready1 = 1'b1; #3;
    wait_until("done_bp_timeout", 2, d0, 3000);
    check("beats_bp_pass", beats1 - b0, 32);
    check("fetch_bp_pass", fetch1 - f0, 16);
    ack_delay = 1;

    // Reset during the fifth beat, then a clean restart
    b0 = beats1;
    pulse_start1();
    wait_until("four_beats_timeout", 4, b0 + 4, 500);
    @(negedge clk); out_ready1 = 1'b0; #3;
    wait_until("beat5_timeout", 0, 0, 20);
    check("beat5_pos", {out_row1, out_col1, out_ch1}, {2'd0, 2'd2, 1'b0});
    @(negedge clk); rst_n = 1'b0; #1;
    check("abort_ctl", {busy1, done1, win_req1, out_valid1}, 0);
    check("abort_pos", {win_row1, win_col1, w_sel1, out_row1, out_col1, out_ch1}, 0);
    check("abort_data", out_data1, 0);
    @(negedge clk); rst_n = 1'b1; out_ready1 = 1'b1;
    b0 = beats1; f0 = fetch1; d0 = dones1;
    pulse_start1();
    wait_until("restart_valid_timeout", 0, 0, 20);
    check("restart_first_pos", {out_row1, out_col1, out_ch1}, 0);
    wait_until("restart_done_timeout", 2, d0, 3000);
    check("restart_beats", beats1 - b0, 32);
    check("restart_fetch", fetch1 - f0, 16);

    // Negative and positive kernel results
    out_ready1 = 1'b0; kr_ovr = 1'b1; kr_val = 16'hFFFB;
    d0 = dones1;
    pulse_start1();
    wait_until("neg_valid_timeout", 0, 0, 20);
    check("neg_result", out_data1, NEG_EXP);
    @(negedge clk); kr_val = 16'h0007; out_ready1 = 1'b1;
    @(negedge clk); out_ready1 = 1'b0; #3;
    wait_until("pos_valid_timeout", 0, 0, 20);
    check("pos_result", {out_data1, 7'(out_ch1)}, {16'h0007, 7'd1});
    @(negedge clk); out_ready1 = 1'b1; #3;
    wait_until("relu_done_timeout", 2, d0, 3000);
    kr_ovr = 1'b0;
    @(negedge clk); #3;
    check("final_idle", {busy1, out_valid1, win_req1}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
